dmem_bridge: RTL
================

# dmem_bridge

Data-side bridge between the RI5CY load/store unit request/grant port and the data SRAM. It converts core transactions into single-cycle SRAM strobes: chip-select, write enable, word address, 32-bit lane mask and write data. It generates the grant and response-valid handshake that matches the SRAM's one-cycle registered read. Optional programmable wait states and an address-range error path make it usable for both nominal and stress simulation.

## Interface
- BASE_ADDR, 32'h0010_0000: byte base address of the data SRAM window.
- ADDR_W, 13: SRAM word-address width; window is 4·2^ADDR_W bytes.
- WAIT_CYCLES, 0: extra cycles between request acceptance and grant (0–15).
- HCLK  in  1  single clock, all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- data_req_i  in  1  core request.
- data_gnt_o  out  1  request accepted this cycle.
- data_rvalid_o  out  1  response valid (loads and stores).
- data_addr_i  in  32  byte address.
- data_we_i  in  1  1 = store.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  store data, lane-aligned.
- data_rdata_o  out  32  load data, lane-aligned, unselected lanes 0.
- data_err_o  out  1  response error, qualified by data_rvalid_o.
- ram_cs_o  out  1  SRAM chip-select.
- ram_we_o  out  1  SRAM write enable.
- ram_addr_o  out  ADDR_W  word address = data_addr_i[ADDR_W+1:2].
- ram_wmask_o  out  32  bit mask; bit 8k+j = data_be_i[k].
- ram_wdata_o  out  32  = data_wdata_i.
- ram_rdata_i  in  32  SRAM registered read data.

## Operation
- FSM states are IDLE and WAIT.
- IDLE: if data_req_i and WAIT_CYCLES==0, grant combinationally this cycle. If WAIT_CYCLES>0, load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0 and data_req_i is high, grant and return to IDLE.
- If data_req_i drops in WAIT, which violates protocol, return to IDLE without a grant or SRAM access.
- Grant cycle: ram_cs_o=1. ram_we_o, ram_addr_o, ram_wmask_o and ram_wdata_o are driven from the core inputs. Outside the grant cycle, ram_cs_o, ram_we_o and ram_wmask_o are 0.
- Response: a flop sets data_rvalid_o=1 exactly one cycle after each grant. data_rdata_o = ram_rdata_i for loads and 0 for stores. Data is not shifted; the LSU aligns it.
- data_be_i==0 is a legal access: a store writes nothing and a load returns 0.
- Core contract: the core holds address, we, be and wdata stable from request to grant.

## Timing
- Reset values: data_gnt_o=0, data_rvalid_o=0, data_err_o=0, data_rdata_o=0, all ram_* outputs 0, FSM=IDLE, counter=0.
- Latency with WAIT_CYCLES=0: request to grant takes 0 cycles, grant to rvalid takes 1 cycle.
- General latency: request to grant takes WAIT_CYCLES cycles.
- Back-to-back: with WAIT_CYCLES=0, a new grant may occur in the same cycle as the previous rvalid, giving one access per cycle.
- With WAIT_CYCLES=N, each subsequent request starts its count in the cycle after the previous grant.
- Reset mid-operation: a pending rvalid is dropped and the counter and FSM clear immediately.
  - A store whose grant edge coincides with HRESETn low is not written; the SRAM gates writes on reset.

## Configuration
- DMEM_BRIDGE_ERR_EN defined: an address outside [BASE_ADDR, BASE_ADDR+4·2^ADDR_W) is still granted normally, but ram_cs_o stays 0.
  - Its rvalid cycle has data_err_o=1 and data_rdata_o=0.
- Undefined: no range check. The upper address bits are ignored, so the window aliases, and data_err_o is tied 0.

## Structure
- Package dmem_pkg holds the FSM state enum, the DMEM_WORDS=2^ADDR_W constant and the be-to-mask expansion function.
- Sub-module dmem_wait_ctr holds the wait-state down-counter with load, decrement and zero flag. The FSM, mask expansion, range check and response flop stay in the top module.

## Test plan
- Load, WAIT_CYCLES=0: SRAM word 0x10 = 0xDEADBEEF; load at 0x0010_0040 with be=4'b1111.
  - Grant in the same cycle, ram_addr_o=0x10.
  - Next cycle: rvalid=1, rdata=0xDEADBEEF, err=0.
- Byte store then load: store 0xAABBCCDD at 0x0010_0042 with be=4'b0100, giving ram_wmask_o=0x00FF0000.
  - A word load then returns 0xDEBBBEEF.
- Back-to-back: 8 alternating store/load requests with req held high.
  - 8 grants in 8 consecutive cycles and 8 rvalids, each lagging its grant by 1 cycle.
  - The read data matches the writes.
- WAIT_CYCLES=3: the request is held, grant comes exactly 3 cycles later and rvalid 4 cycles later.
  - ram_cs_o is high only in the grant cycle.
- With DMEM_BRIDGE_ERR_EN, load at 0x0010_8000: grant, ram_cs_o=0, next cycle rvalid=1, err=1, rdata=0.
  - Without the macro, the same load returns word 0.
- Reset mid-operation: assert HRESETn low in the cycle between grant and rvalid.
  - rvalid is never asserted, all outputs read 0, and the first request after release is serviced normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-side SRAM bridge.
// Holds the bridge FSM state encoding, the SRAM depth constant and the
// byte-enable to bit-mask expansion used on both write and read paths.
package dmem_pkg;

  localparam int DMEM_WORDS  = 8192;
  localparam int DMEM_ADDR_W = $clog2(DMEM_WORDS);
  localparam int NUM_LANES   = 4;
  localparam int VEC_W       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_e;

  // Each byte enable covers one 8-bit lane of the 32-bit word.
  function automatic logic [31:0] be_to_mask(input logic [NUM_LANES-1:0] be);
    logic [NUM_LANES-1:0][VEC_W-1:0] m;
    for (int k = 0; k < NUM_LANES; k++) begin
      m[k] = {VEC_W{be[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: core LSU request/grant port plus SRAM strobe port.
// slave  = bridge view, master = core + SRAM view (testbench side).
interface dmem_bridge_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
) ();

  // core side
  logic              data_req_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [31:0]       data_addr_i;
  logic              data_we_i;
  logic [3:0]        data_be_i;
  logic [31:0]       data_wdata_i;
  logic [31:0]       data_rdata_o;
  logic              data_err_o;

  // SRAM side
  logic              ram_cs_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_wmask_o;
  logic [31:0]       ram_wdata_o;
  logic [31:0]       ram_rdata_i;

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output ram_cs_o, ram_we_o, ram_addr_o, ram_wmask_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  ram_cs_o, ram_we_o, ram_addr_o, ram_wmask_o, ram_wdata_o,
    output ram_rdata_i
  );

endinterface

// File: rtl/dmem_wait_ctr.sv
// dmem_wait_ctr: wait-state down-counter for the bridge.
// Load takes priority over decrement; the count saturates at zero.
module dmem_wait_ctr (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q;

  // count register: load, decrement toward zero, clear on reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                 cnt_q <= '0;
    else if (load)                cnt_q <= load_val;
    else if (dec && cnt_q != '0)  cnt_q <= cnt_q - 4'd1;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: RI5CY LSU request/grant to single-cycle SRAM strobes.
// Grant is combinational from the FSM; rvalid follows every grant by one
// cycle to line up with the SRAM's registered read.
// Optional feature macro: DMEM_BRIDGE_ERR_EN -- out-of-window accesses are
// granted without touching the SRAM and answer with data_err_o=1.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int          ADDR_W      = DMEM_ADDR_W,
  parameter int          WAIT_CYCLES = 0
) (
  input logic           HCLK,
  input logic           HRESETn,
  dmem_bridge_if.slave  bus
);

  localparam int         STAGES   = 1;
  localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LD  = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_e     state_q, state_d;
  logic            gnt;
  logic            access;
  logic            in_range;
  logic            ctr_load, ctr_dec, ctr_zero;
  logic [STAGES:0] vld_pipe;
  logic [31:0]     rsp_mask_q;
  logic            rsp_err_q;

  dmem_wait_ctr u_wait_ctr (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .load     (ctr_load),
    .load_val (WAIT_LD),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next state, grant and counter control; a dropped request in WAIT
  // abandons the access without a grant
  always_comb begin
    state_d  = state_q;
    gnt      = 1'b0;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.data_req_i) begin
          if (HAS_WAIT) begin
            ctr_load = 1'b1;
            state_d  = WAIT;
          end else begin
            gnt = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!bus.data_req_i) begin
          state_d = IDLE;
        end else if (ctr_zero) begin
          gnt     = 1'b1;
          state_d = IDLE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // no grant (hence no SRAM strobe) while reset is asserted
    if (!HRESETn) gnt = 1'b0;
  end

`ifdef DMEM_BRIDGE_ERR_EN
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + (33'd4 << ADDR_W);
  logic [32:0] addr_x;
  assign addr_x   = {1'b0, bus.data_addr_i};
  assign in_range = (addr_x >= WIN_LO) && (addr_x < WIN_HI);
`else
  // window aliases: upper address bits and the byte offset are don't-care
  logic unused_addr;
  assign unused_addr = ^{bus.data_addr_i[31:ADDR_W+2], bus.data_addr_i[1:0], BASE_ADDR};
  assign in_range    = 1'b1;
`endif

  assign access = gnt & in_range;

  assign bus.data_gnt_o  = gnt;
  assign bus.ram_cs_o    = access;
  assign bus.ram_we_o    = access & bus.data_we_i;
  assign bus.ram_wmask_o = access ? be_to_mask(bus.data_be_i) : '0;
  assign bus.ram_addr_o  = gnt ? bus.data_addr_i[ADDR_W+1:2] : '0;
  assign bus.ram_wdata_o = gnt ? bus.data_wdata_i : '0;

  // response valid: grant delayed by one cycle, dropped by reset
  assign vld_pipe[0] = gnt;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) vld_pipe[STAGES:1] <= '0;
    else          vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // response qualifiers: lanes returned for a load, error for out-of-window
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_mask_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (gnt) begin
      rsp_mask_q <= (!bus.data_we_i && in_range) ? be_to_mask(bus.data_be_i) : '0;
      rsp_err_q  <= !in_range;
    end else begin
      rsp_mask_q <= '0;
      rsp_err_q  <= 1'b0;
    end
  end

  assign bus.data_rvalid_o = vld_pipe[STAGES];
  assign bus.data_err_o    = rsp_err_q;
  assign bus.data_rdata_o  = bus.ram_rdata_i & rsp_mask_q;

endmodule
